// File: rtl/paddle_adc_reader.sv
// Polls an ADC128S022 for two paddle channels, averages four samples per
// channel and publishes clamped 8-bit positions with a load strobe.
module paddle_adc_reader #(
  parameter int CLK_DIV   = 8,
  parameter int A_CH      = 0,
  parameter int B_CH      = 1,
  parameter int MAX_POS   = 202,
  parameter int RESET_POS = 101
) (
  input  logic       SYSTEM_CLOCK,
  input  logic       RESET,
  output logic       ADC_CS_N,
  output logic       ADC_SCLK,
  output logic       ADC_DIN,
  input  logic       ADC_DOUT,
  output logic [7:0] PADDLE_A_POSITION,
  output logic [7:0] PADDLE_B_POSITION,
  output logic       POS_STROBE
);

  localparam int            CW          = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LP_HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LP_GAP_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [7:0]    LP_MAX      = 8'(MAX_POS);
  localparam logic [7:0]    LP_RST      = 8'(RESET_POS);
  localparam logic [2:0]    LP_A        = 3'(A_CH);
  localparam logic [2:0]    LP_B        = 3'(B_CH);

  typedef enum logic [1:0] {SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]    r_half, w_half_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          w_start, w_fall, w_rise, w_end;

  logic          r_din;
  logic [15:0]   r_tx;
  logic [11:0]   r_rx;
  logic [11:0]   r_sample;
  logic          r_load, r_load_b;
  logic          r_frame_odd, r_first;
  logic [13:0]   r_acc_a, r_acc_b;
  logic [1:0]    r_cnt_a, r_cnt_b;
  logic [7:0]    r_pos_a, r_pos_b;
  logic          r_strobe;

  logic [15:0]   w_word;
  logic [13:0]   w_acc_sel, w_sum;
  logic [7:0]    w_avg, w_pos;

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (RESET) begin
      r_state <= GAP;
      r_cnt   <= '0;
      r_half  <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sclk  <= w_sclk_nxt;
    end
  end

  // Half-period h of SHIFT has SCLK = h[0]; moving into an odd half is a rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_half_nxt  = r_half;
    w_cs_n_nxt  = r_cs_n;
    w_sclk_nxt  = r_sclk;
    w_start     = 1'b0;
    w_fall      = 1'b0;
    w_rise      = 1'b0;
    w_end       = 1'b0;
    unique case (r_state)
      SETUP: if (r_cnt == LP_HALF_END) begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = '0;
        w_half_nxt  = '0;
        w_sclk_nxt  = 1'b0;
      end
      SHIFT: if (r_cnt == LP_HALF_END) begin
        w_cnt_nxt = '0;
        if (r_half == 5'd31) begin
          w_state_nxt = HOLD;
        end else begin
          w_half_nxt = r_half + 1'b1;
          w_sclk_nxt = ~r_half[0];
          w_rise     = ~r_half[0];
          w_fall     = r_half[0];
        end
      end
      HOLD: if (r_cnt == LP_HALF_END) begin
        w_state_nxt = GAP;
        w_cnt_nxt   = '0;
        w_cs_n_nxt  = 1'b1;
        w_end       = 1'b1;
      end
      GAP: if (r_cnt == LP_GAP_END) begin
        w_state_nxt = SETUP;
        w_cnt_nxt   = '0;
        w_cs_n_nxt  = 1'b0;
        w_start     = 1'b1;
      end
      default: w_state_nxt = GAP;
    endcase
  end

  assign w_word    = {2'b00, (r_frame_odd ? LP_A : LP_B), 11'b0};
  assign w_acc_sel = r_load_b ? r_acc_b : r_acc_a;
  assign w_sum     = w_acc_sel + {2'b00, r_sample};
  assign w_avg     = w_sum[13:6];
  assign w_pos     = (w_avg > LP_MAX) ? LP_MAX : w_avg;

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (RESET) begin
      r_din       <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sample    <= '0;
      r_load      <= 1'b0;
      r_load_b    <= 1'b0;
      r_frame_odd <= 1'b0;
      r_first     <= 1'b1;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_pos_a     <= LP_RST;
      r_pos_b     <= LP_RST;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_load   <= 1'b0;
      if (w_start) begin
        r_din <= w_word[15];
        r_tx  <= {w_word[14:0], 1'b0};
      end
      if (w_fall) begin
        r_din <= r_tx[15];
        r_tx  <= {r_tx[14:0], 1'b0};
      end
      if (w_rise) r_rx <= {r_rx[10:0], ADC_DOUT};
      // Odd frames carry B data, even frames A data; frame 0 is a dummy conversion.
      if (w_end) begin
        r_din       <= 1'b0;
        r_sample    <= r_rx;
        r_load      <= ~r_first;
        r_load_b    <= r_frame_odd;
        r_frame_odd <= ~r_frame_odd;
        r_first     <= 1'b0;
      end
      if (r_load) begin
        if (r_load_b) begin
          r_cnt_b <= r_cnt_b + 1'b1;
          if (r_cnt_b == 2'd3) begin
            r_acc_b  <= '0;
            r_pos_b  <= w_pos;
            r_strobe <= 1'b1;
          end else begin
            r_acc_b <= w_sum;
          end
        end else begin
          r_cnt_a <= r_cnt_a + 1'b1;
          if (r_cnt_a == 2'd3) begin
            r_acc_a  <= '0;
            r_pos_a  <= w_pos;
            r_strobe <= 1'b1;
          end else begin
            r_acc_a <= w_sum;
          end
        end
      end
    end
  end

  assign ADC_CS_N          = r_cs_n;
  assign ADC_SCLK          = r_sclk;
  assign ADC_DIN           = r_din;
  assign PADDLE_A_POSITION = r_pos_a;
  assign PADDLE_B_POSITION = r_pos_b;
  assign POS_STROBE        = r_strobe;

endmodule

// File: tb/tb_paddle_adc_reader.sv
// Bench for paddle_adc_reader: behavioural ADC128S022 model plus a reference
// that averages the values the ADC returned, frame by frame.
module tb_paddle_adc_reader;
  localparam int CLK_DIV   = 8;
  localparam int A_CH      = 0;
  localparam int B_CH      = 1;
  localparam int MAX_POS   = 202;
  localparam int RESET_POS = 101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n, sclk, din;
  logic       dout = 1'b0;
  logic [7:0] pa, pb;
  logic       strobe;

  always #5 clk = ~clk;

  paddle_adc_reader #(
    .CLK_DIV(CLK_DIV), .A_CH(A_CH), .B_CH(B_CH),
    .MAX_POS(MAX_POS), .RESET_POS(RESET_POS)
  ) dut (
    .SYSTEM_CLOCK(clk), .RESET(rst),
    .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_DIN(din), .ADC_DOUT(dout),
    .PADDLE_A_POSITION(pa), .PADDLE_B_POSITION(pb), .POS_STROBE(strobe)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ADC stimulus controls
  logic [11:0] fixval [0:7];
  bit          rnd    [0:7];
  logic [11:0] qa [$];

  // ADC model and reference state
  logic [2:0]  nxt_ch = '0, cur_ch = '0, exp_addr;
  logic [11:0] cur_val = '0;
  logic [15:0] tx_word = '0, din_sr = '0;
  int bitn = 15, falls = 0, rises = 0, frame_idx = 0;
  int sum_a = 0, n_a = 0, sum_b = 0, n_b = 0;
  int exp_a = RESET_POS, exp_b = RESET_POS, exp_strobes = 0, strobes = 0;
  bit mon_en = 0, rst_guard = 1;

  function automatic int clamp(input int v);
    return (v > MAX_POS) ? MAX_POS : v;
  endfunction

  always @(negedge cs_n) begin
    cur_ch = nxt_ch;
    if (frame_idx == 0)                         cur_val = 12'hFFF;
    else if (cur_ch == 3'(A_CH) && qa.size() > 0) cur_val = qa.pop_front();
    else if (rnd[cur_ch])                       cur_val = 12'($urandom_range(0, 4095));
    else                                        cur_val = fixval[cur_ch];
    tx_word = {4'b0000, cur_val};
    bitn = 15; falls = 0; rises = 0; din_sr = '0;
    dout = tx_word[15];
  end

  always @(negedge sclk) if (cs_n === 1'b0) begin
    if (falls > 0 && bitn > 0) begin
      bitn--;
      dout = tx_word[bitn];
    end
    falls++;
  end

  always @(posedge sclk) if (cs_n === 1'b0) begin
    din_sr = {din_sr[14:0], din};
    rises++;
  end

  // Only complete frames count; aborted frames have fewer than 16 clocks.
  always @(posedge cs_n) begin
    if (mon_en && rises == 16) begin
      exp_addr = (frame_idx % 2 == 0) ? 3'(B_CH) : 3'(A_CH);
      check("din_word", din_sr, {2'b00, exp_addr, 11'b0});
      nxt_ch = din_sr[13:11];
      if (frame_idx >= 1) begin
        if (cur_ch == 3'(A_CH)) begin
          sum_a += cur_val; n_a++;
          if (n_a == 4) begin exp_a = clamp(sum_a / 64); exp_strobes++; sum_a = 0; n_a = 0; end
        end else if (cur_ch == 3'(B_CH)) begin
          sum_b += cur_val; n_b++;
          if (n_b == 4) begin exp_b = clamp(sum_b / 64); exp_strobes++; sum_b = 0; n_b = 0; end
        end
      end
      frame_idx++;
    end
  end

  logic       prev_strobe = 1'b0;
  logic [7:0] prev_pa = '0, prev_pb = '0;
  always @(negedge clk) begin
    if (mon_en && !rst_guard) begin
      if (cs_n === 1'b1) check("sclk_idle_high", sclk, 1);
      if (strobe === 1'b1) begin
        strobes++;
        check("strobe_single_cycle", prev_strobe, 0);
      end
      if (pa !== prev_pa || pb !== prev_pb) check("pos_change_needs_strobe", strobe, 1);
    end
    prev_strobe = strobe; prev_pa = pa; prev_pb = pb;
  end

  task automatic wait_cs(input logic lvl);
    int cnt = 0;
    while (cs_n !== lvl && cnt < 40 * CLK_DIV) begin @(negedge clk); cnt++; end
    if (cs_n !== lvl) check("wait_cs_timeout", cs_n, lvl);
  endtask

  task automatic do_reset();
    int cnt;
    @(negedge clk); rst = 1'b1; rst_guard = 1;
    @(posedge clk); #1;
    nxt_ch = '0; frame_idx = 0; rises = 0;
    sum_a = 0; n_a = 0; sum_b = 0; n_b = 0;
    exp_a = RESET_POS; exp_b = RESET_POS; exp_strobes = 0; strobes = 0;
    @(negedge clk); rst = 1'b0;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_din", din, 0);
    check("rst_strobe", strobe, 0);
    check("rst_pos_a", pa, RESET_POS);
    check("rst_pos_b", pb, RESET_POS);
    mon_en = 1;
    cnt = 0;
    while (cs_n === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    check("rst_to_cs_fall", cnt, 2 * CLK_DIV);
    rst_guard = 0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      wait_cs(1'b1);
      wait_cs(1'b0);
      check("pos_a_model", pa, exp_a);
      check("pos_b_model", pb, exp_b);
      check("strobe_count_model", strobes, exp_strobes);
    end
  endtask

  task automatic measure_frame();
    int lo = 0, hi = 0, rs = 0;
    logic prev_s;
    wait_cs(1'b0);
    prev_s = sclk;
    while (cs_n === 1'b0 && lo < 1000) begin
      lo++;
      @(negedge clk);
      if (sclk === 1'b1 && prev_s === 1'b0) rs++;
      prev_s = sclk;
    end
    while (cs_n === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
    check("cs_low_cycles", lo, 34 * CLK_DIV);
    check("cs_high_cycles", hi, 2 * CLK_DIV);
    check("sclk_rises", rs, 16);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 8; i++) begin fixval[i] = '0; rnd[i] = 0; end

    // Reset state and idle frame timing
    do_reset();
    measure_frame();
    measure_frame();

    // Full scale: A clamps, B averages to 64
    fixval[0] = 12'hFFF; fixval[1] = 12'h400;
    do_reset();
    run_frames(9);
    check("full_a", pa, 202);
    check("full_b", pb, 64);
    check("full_strobes_8f", strobes, 2);
    run_frames(8);
    check("full_strobes_16f", strobes, 4);

    // Averaging: three samples leave A untouched, the fourth loads 127
    qa = '{12'h000, 12'h000, 12'hFFC, 12'hFFC};
    do_reset();
    run_frames(7);
    check("avg_3_samples_a", pa, RESET_POS);
    check("avg_3_samples_strobes", strobes, 0);
    run_frames(2);
    check("avg_4_samples_a", pa, 127);

    // Clamp boundary
    fixval[0] = 12'hCA0;
    do_reset();
    run_frames(9);
    check("bound_ca0", pa, 202);
    fixval[0] = 12'hCB0;
    do_reset();
    run_frames(9);
    check("bound_cb0", pa, 202);

    // Reset mid-frame drops the partial A accumulation
    fixval[0] = 12'hFFF; rnd[1] = 1;
    do_reset();
    run_frames(5);
    cnt = 0;
    while (rises < 8 && cnt < 1000) begin @(negedge clk); cnt++; end
    check("midreset_reached_bit", (rises >= 8), 1);
    fixval[0] = 12'h400;
    do_reset();
    run_frames(7);
    check("midreset_a_waits", pa, RESET_POS);
    run_frames(2);
    check("midreset_a_fresh", pa, 64);

    // Random samples on both channels
    rnd[0] = 1; rnd[1] = 1;
    do_reset();
    run_frames(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
